// File: rtl/fetch_unit_if.sv
// Instruction-fetch bus: imem read channel, redirect input and decode handshake.
// master = fetch_unit side, slave = memory/decode environment side.
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] imem_addr_out;
  logic              imem_req_out;
  logic [DATA_W-1:0] imem_data_in;
  logic              redirect_in;
  logic [ADDR_W-1:0] redirect_pc_in;
  logic [DATA_W-1:0] ins_out;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pcn_out;
  logic              valid_out;
  logic              ready_in;

  modport master (
    output imem_addr_out, imem_req_out, ins_out, pc_out, pcn_out, valid_out,
    input  imem_data_in, redirect_in, redirect_pc_in, ready_in
  );

  modport slave (
    input  imem_addr_out, imem_req_out, ins_out, pc_out, pcn_out, valid_out,
    output imem_data_in, redirect_in, redirect_pc_in, ready_in
  );
endinterface

// File: rtl/fetch_unit.sv
// Prefetching instruction fetch unit with a DEPTH-entry {pc, ins} queue.
// Optional macro FETCH_PERF_CNT_EN adds redirect/stall performance counters.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0040_0000),
  parameter int                DEPTH    = 4
) (
  input  logic          clock,
  input  logic          reset,
  fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   redirect_count_out,
  output logic [31:0]   stall_count_out
`endif
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam int                INF_W   = CNT_W + 1;
  localparam logic [INF_W-1:0]  DEPTH_L = INF_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(4);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_req_q;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_pc_mem  [DEPTH];
  logic [DATA_W-1:0] r_ins_mem [DEPTH];

  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_addr;
  logic [INF_W-1:0]  w_inflight;
  logic              w_req;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;

  always_comb begin
    w_target   = bus.redirect_pc_in & ~ADDR_W'(3);
    // Queued entries plus the response still in flight must leave a free slot.
    w_inflight = {1'b0, r_count} + {{CNT_W{1'b0}}, r_req_q};
    w_valid    = (r_count != '0);
    w_req      = 1'b0;
    w_addr     = RESET_PC;
    if (reset) begin
      w_req  = bus.redirect_in | (w_inflight < DEPTH_L);
      w_addr = bus.redirect_in ? w_target : r_fetch_pc;
    end
    w_push = r_req_q & ~bus.redirect_in;
    w_pop  = w_valid & bus.ready_in & ~bus.redirect_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_req_q    <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_req_q <= w_req;
      if (w_req) begin
        r_fetch_pc <= w_addr + STEP;
        r_req_addr <= w_addr;
      end
      if (bus.redirect_in) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // NOTE: queue storage has no reset; an entry is only observable once r_count
  // covers it, so clearing the array would add reset fan-out for no behaviour.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]  <= r_req_addr;
      r_ins_mem[r_wr_ptr] <= bus.imem_data_in;
    end
  end

  assign bus.imem_addr_out = w_addr;
  assign bus.imem_req_out  = w_req;
  assign bus.valid_out     = w_valid;
  assign bus.ins_out       = r_ins_mem[r_rd_ptr];
  assign bus.pc_out        = r_pc_mem[r_rd_ptr];
  assign bus.pcn_out       = r_pc_mem[r_rd_ptr] + STEP;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_redirect_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_redirect_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (bus.redirect_in) r_redirect_cnt <= r_redirect_cnt + 32'd1;
      if (!w_valid)        r_stall_cnt    <= r_stall_cnt + 32'd1;
    end
  end

  assign redirect_count_out = r_redirect_cnt;
  assign stall_count_out    = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (DEPTH=4 defaults).
// Define FETCH_PERF_CNT_EN to also exercise the performance counters.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0040_0000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redirect_count_out;
  logic [31:0] stall_count_out;
`endif

  fetch_unit dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .redirect_count_out(redirect_count_out),
    .stall_count_out   (stall_count_out)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Instruction memory: data for the address seen at an edge is returned the next cycle.
  always @(posedge clock) bus.imem_data_in <= ins_of(bus.imem_addr_out);

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench in the first cycle after reset release.
  task automatic do_reset(input logic rdy);
    reset = 1'b0;
    bus.redirect_in = 1'b0;
    bus.ready_in = rdy;
    cyc();
    cyc();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.ready_in = 1'b1;
    bus.redirect_in = 1'b1;
    bus.redirect_pc_in = 32'h1234_5678;
    cyc();
    cyc();
    n_vec++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.valid_out); end
    n_vec++; if (bus.imem_req_out !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", bus.imem_req_out); end
    n_vec++; if (bus.imem_addr_out !== RPC) begin n_err++; $display("FAIL reset_addr: got %h want %h", bus.imem_addr_out, RPC); end
    bus.redirect_in = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      n_vec++; if (bus.imem_req_out !== 1'b1 || bus.imem_addr_out !== RPC + 32'(4*k)) begin
        n_err++; $display("FAIL stream_req[%0d]: got req=%b addr=%h want req=1 addr=%h", k, bus.imem_req_out, bus.imem_addr_out, RPC + 32'(4*k));
      end
      if (k < 2) begin
        n_vec++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL stream_early_valid[%0d]: got %b want 0", k, bus.valid_out); end
      end else begin
        exp_pc = RPC + 32'(4*(k-2));
        n_vec++; if (bus.valid_out !== 1'b1 || bus.pc_out !== exp_pc || bus.ins_out !== ins_of(exp_pc) || bus.pcn_out !== exp_pc + 32'd4) begin
          n_err++; $display("FAIL stream_head[%0d]: got v=%b pc=%h ins=%h pcn=%h want v=1 pc=%h ins=%h pcn=%h", k, bus.valid_out, bus.pc_out, bus.ins_out, bus.pcn_out, exp_pc, ins_of(exp_pc), exp_pc + 32'd4);
        end
      end
      cyc();
    end
  endtask

  task automatic test_stall();
    int nreq = 0;
    do_reset(1'b0);
    for (int k = 0; k < 10; k++) begin
      if (bus.imem_req_out === 1'b1) nreq++;
      cyc();
    end
    n_vec++; if (nreq !== 4) begin n_err++; $display("FAIL stall_req_count: got %0d want 4", nreq); end
    n_vec++; if (bus.imem_req_out !== 1'b0) begin n_err++; $display("FAIL stall_req_full: got %b want 0", bus.imem_req_out); end
    n_vec++; if (bus.valid_out !== 1'b1 || bus.pc_out !== RPC) begin n_err++; $display("FAIL stall_head: got v=%b pc=%h want v=1 pc=%h", bus.valid_out, bus.pc_out, RPC); end
    bus.ready_in = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      n_vec++; if (bus.valid_out !== 1'b1 || bus.pc_out !== RPC + 32'(4*k) || bus.ins_out !== ins_of(RPC + 32'(4*k))) begin
        n_err++; $display("FAIL stall_drain[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h", k, bus.valid_out, bus.pc_out, bus.ins_out, RPC + 32'(4*k));
      end
      cyc();
    end
  endtask

  task automatic test_redirect_full();
    do_reset(1'b0);
    repeat (10) cyc();
    bus.redirect_in = 1'b1;
    bus.redirect_pc_in = 32'h0040_0103;
    #1;
    n_vec++; if (bus.imem_addr_out !== 32'h0040_0100 || bus.imem_req_out !== 1'b1) begin
      n_err++; $display("FAIL redir_full_addr: got addr=%h req=%b want addr=00400100 req=1", bus.imem_addr_out, bus.imem_req_out);
    end
    cyc();
    bus.redirect_in = 1'b0;
    #1;
    n_vec++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL redir_full_flush: got %b want 0", bus.valid_out); end
    n_vec++; if (bus.imem_addr_out !== 32'h0040_0104) begin n_err++; $display("FAIL redir_full_next: got %h want 00400104", bus.imem_addr_out); end
    cyc();
    n_vec++; if (bus.valid_out !== 1'b1 || bus.pc_out !== 32'h0040_0100 || bus.ins_out !== ins_of(32'h0040_0100)) begin
      n_err++; $display("FAIL redir_full_head: got v=%b pc=%h ins=%h want v=1 pc=00400100", bus.valid_out, bus.pc_out, bus.ins_out);
    end
  endtask

  task automatic test_redirect_pop();
    do_reset(1'b1);
    repeat (4) cyc();
    bus.redirect_in = 1'b1;
    bus.redirect_pc_in = 32'h0040_0200;
    #1;
    n_vec++; if (bus.valid_out !== 1'b1 || bus.pc_out !== RPC + 32'd8) begin
      n_err++; $display("FAIL redir_pop_pre: got v=%b pc=%h want v=1 pc=%h", bus.valid_out, bus.pc_out, RPC + 32'd8);
    end
    cyc();
    bus.redirect_in = 1'b0;
    #1;
    n_vec++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL redir_pop_stale: got %b want 0", bus.valid_out); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_vec++; if (bus.valid_out !== 1'b1 || bus.pc_out !== 32'h0040_0200 + 32'(4*k)) begin
        n_err++; $display("FAIL redir_pop_head[%0d]: got v=%b pc=%h want v=1 pc=%h", k, bus.valid_out, bus.pc_out, 32'h0040_0200 + 32'(4*k));
      end
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    bus.redirect_in = 1'b1;
    bus.redirect_pc_in = 32'hFFFF_FFFE;
    #1;
    n_vec++; if (bus.imem_addr_out !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_target: got %h want fffffffc", bus.imem_addr_out); end
    cyc();
    bus.redirect_in = 1'b0;
    #1;
    n_vec++; if (bus.imem_addr_out !== 32'h0) begin n_err++; $display("FAIL wrap_fetch_pc: got %h want 00000000", bus.imem_addr_out); end
    cyc();
    n_vec++; if (bus.pc_out !== 32'hFFFF_FFFC || bus.pcn_out !== 32'h0) begin
      n_err++; $display("FAIL wrap_pcn: got pc=%h pcn=%h want pc=fffffffc pcn=00000000", bus.pc_out, bus.pcn_out);
    end
    cyc();
    n_vec++; if (bus.valid_out !== 1'b1 || bus.pc_out !== 32'h0 || bus.pcn_out !== 32'h4) begin
      n_err++; $display("FAIL wrap_next: got v=%b pc=%h pcn=%h want v=1 pc=00000000 pcn=00000004", bus.valid_out, bus.pc_out, bus.pcn_out);
    end
  endtask

  task automatic test_mid_reset();
    int waited = 0;
    do_reset(1'b1);
    repeat (5) cyc();
    reset = 1'b0;
    #1;
    n_vec++; if (bus.valid_out !== 1'b0 || bus.imem_req_out !== 1'b0 || bus.imem_addr_out !== RPC) begin
      n_err++; $display("FAIL midrst_outputs: got v=%b req=%b addr=%h want v=0 req=0 addr=%h", bus.valid_out, bus.imem_req_out, bus.imem_addr_out, RPC);
    end
    cyc();
    reset = 1'b1;
    #1;
    n_vec++; if (bus.imem_req_out !== 1'b1 || bus.imem_addr_out !== RPC) begin
      n_err++; $display("FAIL midrst_first_req: got req=%b addr=%h want req=1 addr=%h", bus.imem_req_out, bus.imem_addr_out, RPC);
    end
    while (bus.valid_out !== 1'b1 && waited < 10) begin
      cyc();
      waited++;
    end
    n_vec++; if (waited !== 2 || bus.pc_out !== RPC) begin
      n_err++; $display("FAIL midrst_head: got latency=%0d pc=%h want latency=2 pc=%h", waited, bus.pc_out, RPC);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    do_reset(1'b1);
    n_vec++; if (redirect_count_out !== 32'd0 || stall_count_out !== 32'd0) begin
      n_err++; $display("FAIL perf_reset: got redir=%0d stall=%0d want 0 0", redirect_count_out, stall_count_out);
    end
    cyc();
    cyc();
    n_vec++; if (stall_count_out !== 32'd2) begin n_err++; $display("FAIL perf_stall: got %0d want 2", stall_count_out); end
    for (int i = 0; i < 3; i++) begin
      bus.redirect_in = 1'b1;
      bus.redirect_pc_in = RPC + 32'(256*(i+1));
      cyc();
      bus.redirect_in = 1'b0;
      cyc();
      cyc();
    end
    n_vec++; if (redirect_count_out !== 32'd3) begin n_err++; $display("FAIL perf_redirects: got %0d want 3", redirect_count_out); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.redirect_in = 1'b0;
    bus.redirect_pc_in = '0;
    bus.ready_in = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_pop();
    test_wrap();
    test_mid_reset();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
